// File: rtl/eth_dispatch_pkg.sv
// Shared constants, state encoding and EtherType helper for the eth_dispatch steering stage.
package eth_dispatch_pkg;

    localparam int BEAT_W = 512;

    localparam logic [15:0] ETYPE_IPV6 = 16'h86DD;
    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

    // Bytes 12-13 of a beat whose byte 0 sits at the MSBs.
    localparam int ETYPE_MSB = BEAT_W - 97;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } disp_state_t;

    function automatic logic [15:0] etype_of(input logic [BEAT_W-1:0] beat);
        return beat[ETYPE_MSB -: 16];
    endfunction

endpackage

// File: rtl/eth_dispatch_if.sv
// Avalon-ST input/output bundle of eth_dispatch; the slave modport is the dispatcher's view.
interface eth_dispatch_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int EMPTY_WIDTH = 6,
    parameter int DST_WIDTH   = 4,
    parameter int VC_WIDTH    = 1
);
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sop;
    logic                   in_eop;
    logic [EMPTY_WIDTH-1:0] in_empty;

    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_sop;
    logic                   out_eop;
    logic [EMPTY_WIDTH-1:0] out_empty;
    logic [DST_WIDTH-1:0]   o_noc_dst;
    logic [VC_WIDTH-1:0]    o_vc_id;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_empty,
               o_noc_dst, o_vc_id
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty,
               o_noc_dst, o_vc_id
    );

endinterface

// File: rtl/eth_dispatch_outreg.sv
// Single output register stage of eth_dispatch: holds all fields while stalled.
module eth_dispatch_outreg #(
    parameter int DATA_WIDTH  = 512,
    parameter int EMPTY_WIDTH = 6,
    parameter int DST_WIDTH   = 4,
    parameter int VC_WIDTH    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   sop,
    input  logic                   eop,
    input  logic [EMPTY_WIDTH-1:0] empty,
    input  logic [DST_WIDTH-1:0]   dst,
    input  logic [VC_WIDTH-1:0]    vc,
    input  logic                   out_ready,
    output logic                   stage_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic [DST_WIDTH-1:0]   o_noc_dst,
    output logic [VC_WIDTH-1:0]    o_vc_id
);

    assign stage_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_empty <= '0;
            o_noc_dst <= '0;
            o_vc_id   <= '0;
        end else if (stage_ready) begin
            out_valid <= load;
            if (load) begin
                out_data  <= data;
                out_sop   <= sop;
                out_eop   <= eop;
                out_empty <= empty;
                o_noc_dst <= dst;
                o_vc_id   <= vc;
            end
        end
    end

endmodule

// File: rtl/eth_dispatch.sv
// EtherType steering: IPv6 round-robin over parser nodes, IPv4 to one node, others dropped.
// Optional DISPATCH_STATS_EN adds saturating packet/beat statistics counters.
module eth_dispatch
    import eth_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH  = BEAT_W,
    parameter int EMPTY_WIDTH = 6,
    parameter int NUM_VC      = 2,
    parameter int NOC_RADIX   = 16,
    parameter int NUM_IPV6    = 4,
    parameter int IPV6_BASE   = 4,
    parameter int IPV4_DEST   = 8
) (
    input  logic clk,
    input  logic reset,
    eth_dispatch_if.slave bus
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0] stat_ipv6_pkts,
    output logic [31:0] stat_ipv4_pkts,
    output logic [31:0] stat_drop_pkts,
    output logic [31:0] stat_orphan_beats,
    output logic [31:0] stat_frame_err
`endif
);

    localparam int DST_W = $clog2(NOC_RADIX);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int RR_W  = (NUM_IPV6 > 1) ? $clog2(NUM_IPV6) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_FWD  = FWD;
    localparam logic [1:0] ST_DROP = DROP;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [RR_W-1:0]  rr_ptr;
    logic [VC_W-1:0]  vc_ctr;
    logic [DST_W-1:0] pkt_dst;
    logic [VC_W-1:0]  pkt_vc;

    logic [15:0]      etype;
    logic             is_ipv6;
    logic             is_ipv4;
    logic             known;
    logic             stage_ready;
    logic             accept;
    logic             start;
    logic             fwd_beat;
    logic [DST_W-1:0] cls_dst;
    logic [DST_W-1:0] load_dst;
    logic [VC_W-1:0]  load_vc;

    assign etype   = etype_of(bus.in_data);
    assign is_ipv6 = (etype == ETYPE_IPV6);
    assign is_ipv4 = (etype == ETYPE_IPV4);
    assign known   = is_ipv6 || is_ipv4;

    // A sop arriving in DROP may need the output stage, so it waits for it like any other start.
    assign bus.in_ready = (state == ST_DROP && !bus.in_sop) ? 1'b1 : stage_ready;

    assign accept   = bus.in_valid && bus.in_ready;
    assign start    = accept && bus.in_sop;
    assign fwd_beat = start ? known : (accept && state == ST_FWD);

    assign cls_dst  = is_ipv6 ? (DST_W'(IPV6_BASE) + DST_W'(rr_ptr)) : DST_W'(IPV4_DEST);
    assign load_dst = bus.in_sop ? cls_dst : pkt_dst;
    assign load_vc  = bus.in_sop ? vc_ctr : pkt_vc;

    always_comb begin
        state_nxt = state;
        if (start) begin
            if (bus.in_eop)
                state_nxt = ST_IDLE;
            else
                state_nxt = known ? ST_FWD : ST_DROP;
        end else if (accept && bus.in_eop) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            vc_ctr  <= '0;
            pkt_dst <= '0;
            pkt_vc  <= '0;
        end else begin
            state <= state_nxt;
            if (start && known) begin
                pkt_dst <= cls_dst;
                pkt_vc  <= vc_ctr;
                vc_ctr  <= (vc_ctr == VC_W'(NUM_VC - 1)) ? '0 : vc_ctr + 1'b1;
            end
            if (start && is_ipv6)
                rr_ptr <= (rr_ptr == RR_W'(NUM_IPV6 - 1)) ? '0 : rr_ptr + 1'b1;
        end
    end

    eth_dispatch_outreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .EMPTY_WIDTH(EMPTY_WIDTH),
        .DST_WIDTH  (DST_W),
        .VC_WIDTH   (VC_W)
    ) u_outreg (
        .clk        (clk),
        .reset      (reset),
        .load       (fwd_beat),
        .data       (bus.in_data),
        .sop        (bus.in_sop),
        .eop        (bus.in_eop),
        .empty      (bus.in_empty),
        .dst        (load_dst),
        .vc         (load_vc),
        .out_ready  (bus.out_ready),
        .stage_ready(stage_ready),
        .out_data   (bus.out_data),
        .out_valid  (bus.out_valid),
        .out_sop    (bus.out_sop),
        .out_eop    (bus.out_eop),
        .out_empty  (bus.out_empty),
        .o_noc_dst  (bus.o_noc_dst),
        .o_vc_id    (bus.o_vc_id)
    );

`ifdef DISPATCH_STATS_EN
    logic orphan;
    logic frame_err;

    assign orphan    = accept && !bus.in_sop && state == ST_IDLE;
    assign frame_err = start && state != ST_IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ipv6_pkts    <= '0;
            stat_ipv4_pkts    <= '0;
            stat_drop_pkts    <= '0;
            stat_orphan_beats <= '0;
            stat_frame_err    <= '0;
        end else begin
            if (start && is_ipv6 && stat_ipv6_pkts != '1)
                stat_ipv6_pkts <= stat_ipv6_pkts + 32'd1;
            if (start && is_ipv4 && stat_ipv4_pkts != '1)
                stat_ipv4_pkts <= stat_ipv4_pkts + 32'd1;
            if (start && !known && stat_drop_pkts != '1)
                stat_drop_pkts <= stat_drop_pkts + 32'd1;
            if (orphan && stat_orphan_beats != '1)
                stat_orphan_beats <= stat_orphan_beats + 32'd1;
            if (frame_err && stat_frame_err != '1)
                stat_frame_err <= stat_frame_err + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_dispatch.sv
// Directed testbench for eth_dispatch; checks routing, stalls, drops, framing and reset recovery.
module tb_eth_dispatch;

    localparam logic [15:0] ETH6 = 16'h86DD;
    localparam logic [15:0] ETH4 = 16'h0800;

    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [15:0] etype;
        logic [5:0]  empty;
        logic [7:0]  tag;
    } beat_t;

    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [3:0]  dst;
        logic        vc;
        logic [15:0] etype;
        logic [5:0]  empty;
        logic [7:0]  tag;
    } out_t;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    eth_dispatch_if bus ();

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_ipv6_pkts;
    logic [31:0] stat_ipv4_pkts;
    logic [31:0] stat_drop_pkts;
    logic [31:0] stat_orphan_beats;
    logic [31:0] stat_frame_err;
`endif

    eth_dispatch dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_ipv6_pkts   (stat_ipv6_pkts),
        .stat_ipv4_pkts   (stat_ipv4_pkts),
        .stat_drop_pkts   (stat_drop_pkts),
        .stat_orphan_beats(stat_orphan_beats),
        .stat_frame_err   (stat_frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] make_beat(input logic [15:0] et, input logic [7:0] tg);
        logic [511:0] d;
        d = '0;
        d[415 -: 16] = et;
        d[511 -: 8]  = tg ^ 8'hA5;
        d[7:0]       = tg;
        return d;
    endfunction

    function automatic beat_t bt(input logic s, input logic e, input logic [15:0] et,
                                 input logic [5:0] em, input logic [7:0] tg);
        return '{1'b1, s, e, et, em, tg};
    endfunction

    function automatic out_t ex(input logic s, input logic e, input logic [3:0] d, input logic v,
                                input logic [15:0] et, input logic [5:0] em, input logic [7:0] tg);
        return '{1'b1, s, e, d, v, et, em, tg};
    endfunction

    // Invalid output cycles collapse to all-zero so only out_valid matters there.
    function automatic out_t observe();
        out_t o;
        o = '0;
        if (bus.out_valid) begin
            o.valid = 1'b1;
            o.sop   = bus.out_sop;
            o.eop   = bus.out_eop;
            o.dst   = bus.o_noc_dst;
            o.vc    = bus.o_vc_id;
            o.etype = bus.out_data[415 -: 16];
            o.empty = bus.out_empty;
            o.tag   = bus.out_data[7:0];
        end
        return o;
    endfunction

    task automatic drive(input beat_t b);
        bus.in_valid = b.valid;
        bus.in_sop   = b.sop;
        bus.in_eop   = b.eop;
        bus.in_empty = b.empty;
        bus.in_data  = make_beat(b.etype, b.tag);
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        drive('0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.o_noc_dst, bus.o_vc_id, bus.out_empty} !== 14'd0
            || bus.out_data !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got valid=%b dst=%0d vc=%0d empty=%0d, required all zero",
                     bus.out_valid, bus.o_noc_dst, bus.o_vc_id, bus.out_empty);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_ipv6_rr();
        beat_t b [4];
        out_t  e [4];
        out_t  o;
        for (int i = 0; i < 4; i++) begin
            b[i] = bt(1'b1, 1'b1, ETH6, 6'd0, 8'(16 + i));
            e[i] = ex(1'b1, 1'b1, 4'(4 + i), 1'(i % 2), ETH6, 6'd0, 8'(16 + i));
        end
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                o = observe();
                checks++;
                if (o !== e[k-1]) begin
                    fails++;
                    $display("[TB] FAIL ipv6_rr beat %0d: got %h required %h", k - 1, o, e[k-1]);
                end
            end
            if (k < 4) drive(b[k]);
            else drive('0);
        end
    endtask

    task automatic test_ipv4_then_drop();
        beat_t b [6];
        out_t  e [6];
        out_t  o;
        b[0] = bt(1'b1, 1'b0, ETH4,     6'd0, 8'h20); e[0] = ex(1'b1, 1'b0, 4'd8, 1'b0, ETH4,  6'd0, 8'h20);
        b[1] = bt(1'b0, 1'b0, 16'h0000, 6'd0, 8'h21); e[1] = ex(1'b0, 1'b0, 4'd8, 1'b0, 16'h0, 6'd0, 8'h21);
        b[2] = bt(1'b0, 1'b1, 16'h0000, 6'd5, 8'h22); e[2] = ex(1'b0, 1'b1, 4'd8, 1'b0, 16'h0, 6'd5, 8'h22);
        b[3] = bt(1'b1, 1'b0, 16'h88CC, 6'd0, 8'h23); e[3] = '0;
        b[4] = bt(1'b0, 1'b1, 16'h0000, 6'd0, 8'h24); e[4] = '0;
        b[5] = bt(1'b1, 1'b1, ETH6,     6'd0, 8'h25); e[5] = ex(1'b1, 1'b1, 4'd4, 1'b1, ETH6, 6'd0, 8'h25);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                o = observe();
                checks++;
                if (o !== e[k-1]) begin
                    fails++;
                    $display("[TB] FAIL ipv4_drop beat %0d: got %h required %h", k - 1, o, e[k-1]);
                end
            end
            if (k < 6) drive(b[k]);
            else drive('0);
            if (k == 3 || k == 4) begin
                #1;
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL drop_in_ready beat %0d: got %b required 1", k, bus.in_ready);
                end
            end
        end
    endtask

    task automatic test_stall();
        beat_t b [6];
        out_t  e [6];
        logic  ordy [6];
        logic  rdy [6];
        out_t  o;
        beat_t ba;
        beat_t bb;
        out_t  ea;
        out_t  eb;
        ba = bt(1'b1, 1'b0, ETH6, 6'd0, 8'h30);
        bb = bt(1'b0, 1'b0, 16'h0, 6'd0, 8'h31);
        ea = ex(1'b1, 1'b0, 4'd5, 1'b0, ETH6, 6'd0, 8'h30);
        eb = ex(1'b0, 1'b0, 4'd5, 1'b0, 16'h0, 6'd0, 8'h31);
        b[0] = ba; ordy[0] = 1'b1; rdy[0] = 1'b1; e[0] = ea;
        b[1] = bb; ordy[1] = 1'b0; rdy[1] = 1'b0; e[1] = ea;
        b[2] = bb; ordy[2] = 1'b0; rdy[2] = 1'b0; e[2] = ea;
        b[3] = bb; ordy[3] = 1'b1; rdy[3] = 1'b1; e[3] = eb;
        b[4] = bt(1'b0, 1'b1, 16'h0, 6'd13, 8'h32); ordy[4] = 1'b1; rdy[4] = 1'b1;
        e[4] = ex(1'b0, 1'b1, 4'd5, 1'b0, 16'h0, 6'd13, 8'h32);
        b[5] = '0; ordy[5] = 1'b1; rdy[5] = 1'b1; e[5] = '0;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                o = observe();
                checks++;
                if (o !== e[k-1]) begin
                    fails++;
                    $display("[TB] FAIL stall cycle %0d: got %h required %h", k - 1, o, e[k-1]);
                end
            end
            if (k < 6) begin
                drive(b[k]);
                bus.out_ready = ordy[k];
                #1;
                checks++;
                if (bus.in_ready !== rdy[k]) begin
                    fails++;
                    $display("[TB] FAIL stall_in_ready cycle %0d: got %b required %b", k, bus.in_ready, rdy[k]);
                end
            end
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_frame_error();
        beat_t b [4];
        out_t  e [4];
        out_t  o;
        b[0] = bt(1'b1, 1'b0, ETH6, 6'd0, 8'h40); e[0] = ex(1'b1, 1'b0, 4'd6, 1'b1, ETH6,  6'd0, 8'h40);
        b[1] = bt(1'b0, 1'b0, 16'h0, 6'd0, 8'h41); e[1] = ex(1'b0, 1'b0, 4'd6, 1'b1, 16'h0, 6'd0, 8'h41);
        b[2] = bt(1'b1, 1'b1, ETH4, 6'd0, 8'h42); e[2] = ex(1'b1, 1'b1, 4'd8, 1'b0, ETH4,  6'd0, 8'h42);
        b[3] = bt(1'b1, 1'b1, ETH6, 6'd0, 8'h43); e[3] = ex(1'b1, 1'b1, 4'd7, 1'b1, ETH6,  6'd0, 8'h43);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                o = observe();
                checks++;
                if (o !== e[k-1]) begin
                    fails++;
                    $display("[TB] FAIL frame_error beat %0d: got %h required %h", k - 1, o, e[k-1]);
                end
            end
            if (k < 4) drive(b[k]);
            else drive('0);
        end
`ifdef DISPATCH_STATS_EN
        checks++;
        if (stat_frame_err !== 32'd1) begin
            fails++;
            $display("[TB] FAIL stat_frame_err: got %0d required 1", stat_frame_err);
        end
`endif
    endtask

    task automatic test_orphan();
        out_t o;
        @(negedge clk);
        drive(bt(1'b0, 1'b0, ETH6, 6'd0, 8'h50));
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL orphan_in_ready: got %b required 1", bus.in_ready);
        end
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== '0) begin
            fails++;
            $display("[TB] FAIL orphan_output: got %h required %h", o, out_t'('0));
        end
        drive('0);
        @(negedge clk);
`ifdef DISPATCH_STATS_EN
        checks++;
        if ({stat_orphan_beats, stat_ipv6_pkts, stat_ipv4_pkts, stat_drop_pkts}
            !== {32'd1, 32'd8, 32'd2, 32'd1}) begin
            fails++;
            $display("[TB] FAIL stats_totals: got orphan=%0d ipv6=%0d ipv4=%0d drop=%0d required 1 8 2 1",
                     stat_orphan_beats, stat_ipv6_pkts, stat_ipv4_pkts, stat_drop_pkts);
        end
`endif
    endtask

    task automatic test_reset_mid_packet();
        out_t o;
        out_t e;
        @(negedge clk);
        drive(bt(1'b1, 1'b0, ETH6, 6'd0, 8'h60));
        @(negedge clk);
        o = observe();
        e = ex(1'b1, 1'b0, 4'd4, 1'b0, ETH6, 6'd0, 8'h60);
        checks++;
        if (o !== e) begin
            fails++;
            $display("[TB] FAIL pre_reset_beat: got %h required %h", o, e);
        end
        drive(bt(1'b0, 1'b0, 16'h0, 6'd0, 8'h61));
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.o_noc_dst, bus.o_vc_id, bus.out_empty} !== 14'd0
            || bus.out_data !== '0) begin
            fails++;
            $display("[TB] FAIL async_reset_clear: got valid=%b dst=%0d vc=%0d, required all zero",
                     bus.out_valid, bus.o_noc_dst, bus.o_vc_id);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== '0) begin
            fails++;
            $display("[TB] FAIL orphan_after_reset 1: got %h required 0", o);
        end
        drive(bt(1'b0, 1'b1, 16'h0, 6'd0, 8'h62));
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== '0) begin
            fails++;
            $display("[TB] FAIL orphan_after_reset 2: got %h required 0", o);
        end
        drive(bt(1'b1, 1'b1, ETH6, 6'd0, 8'h63));
        @(negedge clk);
        o = observe();
        e = ex(1'b1, 1'b1, 4'd4, 1'b0, ETH6, 6'd0, 8'h63);
        checks++;
        if (o !== e) begin
            fails++;
            $display("[TB] FAIL post_reset_ipv6: got %h required %h", o, e);
        end
        drive('0);
        @(negedge clk);
`ifdef DISPATCH_STATS_EN
        checks++;
        if ({stat_orphan_beats, stat_ipv6_pkts, stat_frame_err} !== {32'd2, 32'd1, 32'd0}) begin
            fails++;
            $display("[TB] FAIL stats_after_reset: got orphan=%0d ipv6=%0d frame=%0d required 2 1 0",
                     stat_orphan_beats, stat_ipv6_pkts, stat_frame_err);
        end
`endif
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_ipv6_rr();
        test_ipv4_then_drop();
        test_stall();
        test_frame_error();
        test_orphan();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
